int_div_rem_rn: RTL



---
 rtl/int_div_rem_rn.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/int_div_rem_rn.sv
// int_div_rem_rn: iterative DIV/DIVU/REM/REMU unit for the execute stage.
// Restoring divider, BITS_PER_CYCLE quotient bits per clock, tag carried along.
module int_div_rem_rn #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5,
   parameter int EARLY_OUT      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dbz,
   output logic             out_ovf,
   output logic             busy,
   output logic [TAG_W-1:0] busy_tag
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ITER,
      FIX,
      OUT
   } state_t;

   state_t state, state_n;

   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [TAG_W-1:0] tag_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] q_r;
   logic [CNT_W-1:0] cnt_r;
   logic             qsign_r;
   logic             rsign_r;
   logic [WIDTH-1:0] res_r;
   logic             dbz_r;
   logic             ovf_r;
   logic             busy_r;
   logic [TAG_W-1:0] btag_r;

   logic             accept;
   logic             in_dbz;
   logic             in_ovf;
   logic             special;
   logic [WIDTH-1:0] special_res;

   logic             sgn;
   logic             sa;
   logic             sb;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic             early;

   logic [WIDTH:0]   acc_n;
   logic [WIDTH-1:0] q_n;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic [WIDTH-1:0] fix_res;

   assign in_ready = ~flush & ((state == IDLE) | ((state == OUT) & out_ready));
   assign accept   = in_valid & in_ready;

   // Early resolution of divide-by-zero and signed overflow at accept
   always_comb begin
      in_dbz      = (in_b == '0);
      in_ovf      = ~in_dbz & ~in_op[0] & (in_a == INT_MIN) & (in_b == '1);
      special     = in_dbz | in_ovf;
      special_res = '0;
      if (in_dbz) special_res = in_op[1] ? in_a : '1;
      else        special_res = in_op[1] ? '0 : in_a;
   end

   // Operand magnitudes and early-out test for the LOAD cycle
   always_comb begin
      sgn   = ~op_r[0];
      sa    = sgn & a_r[WIDTH-1];
      sb    = sgn & b_r[WIDTH-1];
      a_abs = sa ? -a_r : a_r;
      b_abs = sb ? -b_r : b_r;
      early = (EARLY_OUT != 0) && (a_abs < b_abs);
   end

   // Chained restoring steps; b_r holds |b| once iterating
   always_comb begin
      acc_n = {1'b0, acc_r};
      q_n   = q_r;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         acc_n = {acc_n[WIDTH-1:0], q_n[WIDTH-1]};
         q_n   = {q_n[WIDTH-2:0], 1'b0};
         if (acc_n >= {1'b0, b_r}) begin
            acc_n  = acc_n - {1'b0, b_r};
            q_n[0] = 1'b1;
         end
      end
   end

   // Sign fix-up and result selection
   always_comb begin
      q_fix   = qsign_r ? -q_r : q_r;
      r_fix   = rsign_r ? -acc_r : acc_r;
      fix_res = op_r[1] ? r_fix : q_fix;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: if (accept) state_n = special ? OUT : LOAD;
            LOAD: state_n = early ? OUT : ITER;
            ITER: if (cnt_r == CNT_W'(N - 1)) state_n = FIX;
            FIX:  state_n = OUT;
            OUT: begin
               if (out_ready) begin
                  if (accept) state_n = special ? OUT : LOAD;
                  else        state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Datapath, result and bookkeeping registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r    <= '0;
         a_r     <= '0;
         b_r     <= '0;
         tag_r   <= '0;
         acc_r   <= '0;
         q_r     <= '0;
         cnt_r   <= '0;
         qsign_r <= 1'b0;
         rsign_r <= 1'b0;
         res_r   <= '0;
         dbz_r   <= 1'b0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         btag_r  <= '0;
      end else if (flush) begin
         dbz_r  <= 1'b0;
         ovf_r  <= 1'b0;
         busy_r <= 1'b0;
         btag_r <= '0;
      end else begin
         if (accept) begin
            op_r   <= in_op;
            a_r    <= in_a;
            b_r    <= in_b;
            tag_r  <= in_tag;
            busy_r <= 1'b1;
            btag_r <= in_tag;
            dbz_r  <= in_dbz;
            ovf_r  <= in_ovf;
            if (special) res_r <= special_res;
         end else if ((state == OUT) && out_ready) begin
            busy_r <= 1'b0;
            btag_r <= '0;
         end
         case (state)
            LOAD: begin
               acc_r   <= '0;
               q_r     <= a_abs;
               b_r     <= b_abs;
               cnt_r   <= '0;
               qsign_r <= sa ^ sb;
               rsign_r <= sa;
               if (early) res_r <= op_r[1] ? a_r : '0;
            end
            ITER: begin
               acc_r <= acc_n[WIDTH-1:0];
               q_r   <= q_n;
               cnt_r <= cnt_r + CNT_W'(1);
            end
            FIX: res_r <= fix_res;
            default: ;
         endcase
      end
   end

   assign out_valid  = (state == OUT);
   assign out_result = res_r;
   assign out_tag    = tag_r;
   assign out_dbz    = dbz_r;
   assign out_ovf    = ovf_r;
   assign busy       = busy_r;
   assign busy_tag   = btag_r;

endmodule
